// File: rtl/uart_cmd_master.sv
// uart_cmd_master
//   Serial command front-end: receives 8N1 bytes on rx_i, parses 3-byte
//   write ('W', adr, dat) or 2-byte read ('R', adr) commands and runs one
//   Wishbone master cycle per command, with an ack timeout and an
//   inter-byte frame timeout.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-low reset
//   rx_i        UART receive line, idle high, asynchronous to clk_i
//   stb_o       bus strobe, held until ack or timeout
//   we_o        1 = write cycle, 0 = read cycle
//   adr_o[7:0]  register address (held between commands)
//   dat_o[7:0]  write data (held between commands)
//   ack_i       slave acknowledge
//   busy_o      high while a command is being received or executed
//   err_o       one-cycle error pulse
//   err_code_o  cause of last error: 0 ack timeout, 1 frame timeout,
//               2 framing error, 3 overrun
module uart_cmd_master #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int ACK_TIMEOUT   = 255,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       stb_o,
  output logic       we_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int FRM_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(FRAME_TIMEOUT - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  localparam logic [1:0] ERR_ACK_TO   = 2'd0;
  localparam logic [1:0] ERR_FRAME_TO = 2'd1;
  localparam logic [1:0] ERR_FRAMING  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_GET_ADR = 2'd1,
    P_GET_DAT = 2'd2,
    P_BUS     = 2'd3
  } p_state_t;

  // ---------------------------------------------------------------------
  // Synchroniser and edge detect
  // ---------------------------------------------------------------------
  logic rx_meta_r;
  logic rx_sync_r;
  logic rx_prev_r;
  logic rx_fall_s;

  // Two-flop synchroniser plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign rx_fall_s = rx_prev_r & ~rx_sync_r;

  // ---------------------------------------------------------------------
  // 8N1 receiver
  // ---------------------------------------------------------------------
  rx_state_t        rx_state_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_valid_r;
  logic             frame_err_r;

  // Receiver: mid-bit sampling; emits byte_valid or frame_err as 1-cycle pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_state_r   <= RX_IDLE;
      bit_cnt_r    <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          bit_cnt_r <= '0;
          if (rx_fall_s) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (bit_cnt_r == HALF_LAST) begin
            bit_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            // A start bit that has already returned high was a glitch.
            if (!rx_sync_r) begin
              rx_state_r <= RX_DATA;
            end else begin
              rx_state_r <= RX_IDLE;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r <= '0;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r  <= '0;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          bit_cnt_r  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Command parser and bus sequencer
  // ---------------------------------------------------------------------
  p_state_t         p_state_r;
  logic             stb_r;
  logic             we_r;
  logic [7:0]       adr_r;
  logic [7:0]       dat_r;
  logic             busy_r;
  logic             err_r;
  logic [1:0]       err_code_r;
  logic [ACK_W-1:0] ack_cnt_r;
  logic [FRM_W-1:0] frm_cnt_r;

  // Parser/sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      p_state_r  <= P_IDLE;
      stb_r      <= 1'b0;
      we_r       <= 1'b0;
      adr_r      <= 8'h00;
      dat_r      <= 8'h00;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= ERR_ACK_TO;
      ack_cnt_r  <= '0;
      frm_cnt_r  <= '0;
    end else begin
      err_r <= 1'b0;
      case (p_state_r)
        P_IDLE: begin
          if (frame_err_r) begin
            err_r      <= 1'b1;
            err_code_r <= ERR_FRAMING;
          end else if (byte_valid_r) begin
            frm_cnt_r <= '0;
            if (shift_r == CMD_WRITE) begin
              p_state_r <= P_GET_ADR;
              we_r      <= 1'b1;
              busy_r    <= 1'b1;
            end else if (shift_r == CMD_READ) begin
              p_state_r <= P_GET_ADR;
              we_r      <= 1'b0;
              busy_r    <= 1'b1;
            end else begin
              p_state_r <= P_IDLE;
            end
          end else begin
            p_state_r <= P_IDLE;
          end
        end
        P_GET_ADR, P_GET_DAT: begin
          // Framing error outranks a frame timeout landing in the same cycle.
          if (frame_err_r) begin
            p_state_r  <= P_IDLE;
            busy_r     <= 1'b0;
            err_r      <= 1'b1;
            err_code_r <= ERR_FRAMING;
          end else if (byte_valid_r) begin
            frm_cnt_r <= '0;
            if (p_state_r == P_GET_ADR) begin
              adr_r <= shift_r;
            end else begin
              dat_r <= shift_r;
            end
            if ((p_state_r == P_GET_ADR) && we_r) begin
              p_state_r <= P_GET_DAT;
            end else begin
              p_state_r <= P_BUS;
              stb_r     <= 1'b1;
              ack_cnt_r <= '0;
            end
          end else if (frm_cnt_r == FRM_LAST) begin
            p_state_r  <= P_IDLE;
            busy_r     <= 1'b0;
            err_r      <= 1'b1;
            err_code_r <= ERR_FRAME_TO;
          end else begin
            frm_cnt_r <= frm_cnt_r + 1'b1;
          end
        end
        P_BUS: begin
          // Ack is checked before the timeout so a last-moment ack wins.
          if (ack_i) begin
            p_state_r <= P_IDLE;
            stb_r     <= 1'b0;
            busy_r    <= 1'b0;
          end else if (ack_cnt_r == ACK_LAST) begin
            p_state_r  <= P_IDLE;
            stb_r      <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b1;
            err_code_r <= ERR_ACK_TO;
          end else begin
            ack_cnt_r <= ack_cnt_r + 1'b1;
          end
          // The receiver keeps running; anything it completes now is lost.
          // The in-flight bus cycle is never aborted by a receive error.
          if (frame_err_r) begin
            err_r      <= 1'b1;
            err_code_r <= ERR_FRAMING;
          end else if (byte_valid_r) begin
            err_r      <= 1'b1;
            err_code_r <= ERR_OVERRUN;
          end
        end
        default: begin
          p_state_r <= P_IDLE;
          stb_r     <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign stb_o      = stb_r;
  assign we_o       = we_r;
  assign adr_o      = adr_r;
  assign dat_o      = dat_r;
  assign busy_o     = busy_r;
  assign err_o      = err_r;
  assign err_code_o = err_code_r;

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master
//   Directed + randomized bench for uart_cmd_master. Bytes are serialised
//   onto rx; a byte-list parser model predicts the bus transactions and the
//   error codes; a negedge monitor records what the DUT actually did.
module tb_uart_cmd_master;

  localparam int CPB  = 16;
  localparam int ACKT = 8;
  localparam int FRT  = 200;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       stb;
  logic       we;
  logic [7:0] adr;
  logic [7:0] dat;
  logic       ack;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  uart_cmd_master #(
    .CLKS_PER_BIT (CPB),
    .ACK_TIMEOUT  (ACKT),
    .FRAME_TIMEOUT(FRT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_i      (rx),
    .stb_o     (stb),
    .we_o      (we),
    .adr_o     (adr),
    .dat_o     (dat),
    .ack_i     (ack),
    .busy_o    (busy),
    .err_o     (err),
    .err_code_o(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // observed / expected scoreboards
  logic [31:0] obs_txn_q[$];
  int          obs_err_q[$];
  logic [31:0] exp_txn_q[$];
  int          exp_err_q[$];
  logic [7:0]  model_dat;

  // stimulus byte list and stop-bit list
  logic [7:0]  bq[$];
  bit          sq[$];

  // monitor state
  bit          ack_en;
  bit          prev_stb;
  int          stb_len;
  logic        stb_we;
  logic [15:0] stb_ad;
  int          unstable;
  int          busy_late;
  bit          busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor and ack responder: sample on the falling edge.
  initial begin
    ack = 1'b0;
    prev_stb = 1'b0;
    stb_len = 0;
    stb_we = 1'b0;
    stb_ad = 16'h0000;
    unstable = 0;
    busy_late = 0;
    busy_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (err === 1'b1) obs_err_q.push_back(int'(err_code));
      if (busy === 1'b1) busy_seen = 1'b1;
      if (stb === 1'b1) begin
        if (!prev_stb) begin
          stb_len = 0;
          stb_we  = we;
          stb_ad  = {adr, dat};
        end else if (({adr, dat} !== stb_ad) || (we !== stb_we)) begin
          unstable++;
        end
        stb_len++;
        // ack for exactly one cycle, starting one cycle after the strobe
        ack = ack_en && (stb_len == 2);
      end else begin
        ack = 1'b0;
        if (prev_stb) begin
          obs_txn_q.push_back({7'd0, stb_we, stb_ad, stb_len[7:0]});
          if (busy !== 1'b0) busy_late++;
        end
      end
      prev_stb = (stb === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic [7:0] b, input bit s);
    bq.push_back(b);
    sq.push_back(s);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reference: parse the byte list as a host would mean it.
  task automatic model_stream(input bit acked);
    logic [7:0] cmd[$];
    bit         w;
    for (int i = 0; i < bq.size(); i++) begin
      if (!sq[i]) begin
        exp_err_q.push_back(2);
        cmd.delete();
      end else if (cmd.size() == 0) begin
        if (bq[i] == 8'h57 || bq[i] == 8'h52) cmd.push_back(bq[i]);
      end else begin
        cmd.push_back(bq[i]);
        if ((cmd[0] == 8'h52 && cmd.size() == 2) || cmd.size() == 3) begin
          w = (cmd[0] == 8'h57);
          if (w) model_dat = cmd[2];
          if (!acked) exp_err_q.push_back(0);
          exp_txn_q.push_back({7'd0, w, cmd[1], model_dat, acked ? 8'd2 : 8'(ACKT)});
          cmd.delete();
        end
      end
    end
  endtask

  task automatic send_stream(input bit acked);
    ack_en = acked;
    model_stream(acked);
    for (int i = 0; i < bq.size(); i++) send_byte(bq[i], sq[i]);
    repeat (ACKT + 30) @(negedge clk);
    bq.delete();
    sq.delete();
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_ntxn"}, obs_txn_q.size(), exp_txn_q.size());
    for (int i = 0; i < obs_txn_q.size() && i < exp_txn_q.size(); i++)
      chk({tag, "_txn"}, obs_txn_q[i], exp_txn_q[i]);
    chk({tag, "_nerr"}, obs_err_q.size(), exp_err_q.size());
    for (int i = 0; i < obs_err_q.size() && i < exp_err_q.size(); i++)
      chk({tag, "_err"}, obs_err_q[i], exp_err_q[i]);
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_busy_end"}, busy_late, 0);
    chk({tag, "_idle"}, busy, 1'b0);
    obs_txn_q.delete();
    exp_txn_q.delete();
    obs_err_q.delete();
    exp_err_q.delete();
    unstable  = 0;
    busy_late = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_stb"}, stb, 1'b0);
    chk({tag, "_we"}, we, 1'b0);
    chk({tag, "_adr"}, adr, 8'h00);
    chk({tag, "_dat"}, dat, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_code"}, err_code, 2'd0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    bit         is_w;

    rst = 1'b0;
    rx = 1'b1;
    ack_en = 1'b0;
    model_dat = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // fixed write
    add(8'h57, 1'b1); add(8'h12, 1'b1); add(8'hA5, 1'b1);
    send_stream(1'b1);
    check_sb("write");

    // fixed read (dat_o keeps 0xA5)
    add(8'h52, 1'b1); add(8'h83, 1'b1);
    send_stream(1'b1);
    check_sb("read");

    // random commands
    for (int k = 0; k < 4; k++) begin
      is_w = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      d = 8'($urandom);
      add(is_w ? 8'h57 : 8'h52, 1'b1);
      add(a, 1'b1);
      if (is_w) add(d, 1'b1);
      send_stream(1'b1);
      check_sb("rand_cmd");
    end

    // ack timeout, then a normal read
    add(8'h57, 1'b1); add(8'hF0, 1'b1); add(8'h01, 1'b1);
    send_stream(1'b0);
    check_sb("ack_to");
    chk("ack_to_code", err_code, 2'd0);
    add(8'h52, 1'b1); add(8'h10, 1'b1);
    send_stream(1'b1);
    check_sb("after_ack_to");

    // garbage byte then 'W' with a bad stop bit
    busy_seen = 1'b0;
    add(8'h41, 1'b1); add(8'h57, 1'b0);
    send_stream(1'b1);
    check_sb("framing");
    chk("framing_busy_seen", busy_seen, 1'b0);
    chk("framing_code", err_code, 2'd2);

    // frame timeout after 'W', adr
    busy_seen = 1'b0;
    send_byte(8'h57, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (100) @(negedge clk);
    chk("frame_to_busy_hold", busy, 1'b1);
    repeat (FRT) @(negedge clk);
    exp_err_q.push_back(1);
    check_sb("frame_to");
    chk("frame_to_busy_seen", busy_seen, 1'b1);
    chk("frame_to_code", err_code, 2'd1);

    // reset in the middle of the data byte of a write
    a = 8'($urandom) | 8'h01;
    send_byte(8'h57, 1'b1);
    send_byte(a, 1'b1);
    chk("pre_rst_adr", adr, a);
    chk("pre_rst_busy", busy, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(i & 1);
      repeat (CPB) @(negedge clk);
    end
    #2 rst = 1'b0;
    #1 check_reset_values("mid_rst");
    rx = 1'b1;
    repeat (CPB * 6) @(negedge clk);
    rst = 1'b1;
    model_dat = 8'h00;
    repeat (5) @(negedge clk);
    add(8'h52, 1'b1); add(8'h55, 1'b1);
    send_stream(1'b1);
    check_sb("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
